// File: rtl/sad_pkg.sv
// sad_pipe shared helpers: width/depth derivation for the SAD adder tree.
package sad_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_DEF   = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    function automatic int levels(input int n);
        return clog2(n);
    endfunction

    function automatic int sum_w(input int pix_w, input int n);
        return pix_w + clog2(n);
    endfunction

    // Element count entering tree level k (odd tails carried forward).
    function automatic int lvl_cnt(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

    typedef logic [PIX_W_DEF-1:0] pix_t;
    typedef logic [PIX_W_DEF+clog2(WIN_DEF*WIN_DEF)-1:0] sum_t;

endpackage

// File: rtl/sad_pipe_if.sv
// sad_pipe streaming bus: window-pair input and SAD result output.
interface sad_pipe_if #(
    parameter int N     = 9,
    parameter int PIX_W = 8,
    parameter int TAG_W = 6,
    parameter int OUT_W = 12
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*PIX_W-1:0]   win_a;
    logic [N*PIX_W-1:0]   win_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_sad;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, win_a, win_b, in_tag, out_ready,
        input  in_ready, out_valid, out_sad, out_tag
    );

    modport slave (
        input  in_valid, win_a, win_b, in_tag, out_ready,
        output in_ready, out_valid, out_sad, out_tag
    );
endinterface

// File: rtl/sad_tree_level.sv
// One registered level of the SAD adder tree; pairs summed, odd tail
// zero-extended and forwarded.
module sad_tree_level
    import sad_pkg::*;
#(
    parameter  int IN_CNT  = 2,
    parameter  int IN_W    = 8,
    parameter  int TAG_W   = 6,
    localparam int OUT_CNT = (IN_CNT + 1) / 2,
    localparam int OUT_W   = IN_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [IN_CNT*IN_W-1:0]   in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    output logic [OUT_CNT*OUT_W-1:0] out_data,
    output logic [TAG_W-1:0]         out_tag
);
    logic [2*OUT_CNT*IN_W-1:0] in_pad;
    logic [OUT_CNT*OUT_W-1:0]  sum_d, sum_q;
    logic                      valid_d, valid_q;
    logic [TAG_W-1:0]          tag_d, tag_q;

    // Padding with a zero element makes the odd tail a plain pass-through.
    assign in_pad = (2*OUT_CNT*IN_W)'(in_data);

    always_comb begin
        sum_d   = sum_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        if (en) begin
            valid_d = in_valid;
            tag_d   = in_tag;
            for (int i = 0; i < OUT_CNT; i++) begin
                sum_d[i*OUT_W +: OUT_W] =
                    {1'b0, in_pad[(2*i)*IN_W +: IN_W]} +
                    {1'b0, in_pad[(2*i+1)*IN_W +: IN_W]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = sum_q;
    assign out_tag   = tag_q;
endmodule

// File: rtl/sad_pipe.sv
// Pipelined streaming SAD engine: registered |a-b| stage plus adder tree.
// SAD_SAT_EN: clamp results above 2^OUT_W-1 instead of wrapping.
module sad_pipe
    import sad_pkg::*;
#(
    parameter int WIN   = 3,
    parameter int PIX_W = 8,
    parameter int TAG_W = 6,
    parameter int OUT_W = 12
) (
    input  logic      clk,
    input  logic      rst,
    sad_pipe_if.slave bus
);
    localparam int N      = WIN * WIN;
    localparam int LEVELS = levels(N);
    localparam int SUM_W  = sum_w(PIX_W, N);

    logic adv;
    logic out_vld;

    // One global enable: the whole pipe freezes while the output is blocked.
    assign adv          = ~out_vld | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_vld;

    logic [N*PIX_W-1:0] diff_d, diff_q;
    logic               vld0_d, vld0_q;
    logic [TAG_W-1:0]   tag0_d, tag0_q;

    always_comb begin
        diff_d = diff_q;
        vld0_d = vld0_q;
        tag0_d = tag0_q;
        if (adv) begin
            vld0_d = bus.in_valid;
            tag0_d = bus.in_tag;
            for (int i = 0; i < N; i++) begin
                diff_d[i*PIX_W +: PIX_W] =
                    (bus.win_a[i*PIX_W +: PIX_W] > bus.win_b[i*PIX_W +: PIX_W])
                    ? bus.win_a[i*PIX_W +: PIX_W] - bus.win_b[i*PIX_W +: PIX_W]
                    : bus.win_b[i*PIX_W +: PIX_W] - bus.win_a[i*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
            vld0_q <= 1'b0;
            tag0_q <= '0;
        end else begin
            diff_q <= diff_d;
            vld0_q <= vld0_d;
            tag0_q <= tag0_d;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IC = lvl_cnt(N, k);
        localparam int OC = lvl_cnt(N, k + 1);
        localparam int IW = PIX_W + k;

        logic [IC*IW-1:0]     d_in;
        logic                 v_in;
        logic [TAG_W-1:0]     t_in;
        logic [OC*(IW+1)-1:0] d_out;
        logic                 v_out;
        logic [TAG_W-1:0]     t_out;

        if (k == 0) begin : g_first
            assign d_in = diff_q;
            assign v_in = vld0_q;
            assign t_in = tag0_q;
        end else begin : g_next
            assign d_in = g_lvl[k-1].d_out;
            assign v_in = g_lvl[k-1].v_out;
            assign t_in = g_lvl[k-1].t_out;
        end

        sad_tree_level #(
            .IN_CNT (IC),
            .IN_W   (IW),
            .TAG_W  (TAG_W)
        ) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_valid  (v_in),
            .in_data   (d_in),
            .in_tag    (t_in),
            .out_valid (v_out),
            .out_data  (d_out),
            .out_tag   (t_out)
        );
    end

    logic [SUM_W-1:0] sum_fin;

    assign sum_fin     = g_lvl[LEVELS-1].d_out;
    assign out_vld     = g_lvl[LEVELS-1].v_out;
    assign bus.out_tag = g_lvl[LEVELS-1].t_out;

`ifdef SAD_SAT_EN
    if (SUM_W > OUT_W) begin : g_sat
        assign bus.out_sad = (|sum_fin[SUM_W-1:OUT_W]) ? '1
                                                       : sum_fin[OUT_W-1:0];
    end else begin : g_ext
        assign bus.out_sad = OUT_W'(sum_fin);
    end
`else
    assign bus.out_sad = OUT_W'(sum_fin);
`endif
endmodule

// File: tb/tb_sad_pipe.sv
// Directed self-checking bench for sad_pipe: latency, extremes, stalls,
// mid-stream reset and alternate window/output sizes.
module tb_sad_pipe;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sad_pipe_if #(.N(9), .PIX_W(8), .TAG_W(6), .OUT_W(12)) bus ();
    sad_pipe #(.WIN(3), .PIX_W(8), .TAG_W(6), .OUT_W(12)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));

    sad_pipe_if #(.N(16), .PIX_W(8), .TAG_W(6), .OUT_W(12)) bus4 ();
    sad_pipe #(.WIN(4), .PIX_W(8), .TAG_W(6), .OUT_W(12)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave));

    sad_pipe_if #(.N(25), .PIX_W(8), .TAG_W(6), .OUT_W(12)) bus5 ();
    sad_pipe #(.WIN(5), .PIX_W(8), .TAG_W(6), .OUT_W(12)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5.slave));

    sad_pipe_if #(.N(9), .PIX_W(8), .TAG_W(6), .OUT_W(10)) bus10 ();
    sad_pipe #(.WIN(3), .PIX_W(8), .TAG_W(6), .OUT_W(10)) dut10 (
        .clk(clk), .rst(rst), .bus(bus10.slave));

    function automatic logic [71:0] fill(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic int model_sad(input logic [71:0] a, input logic [71:0] b);
        int s;
        int pa;
        int pb;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            pa = int'(a[i*8 +: 8]);
            pb = int'(b[i*8 +: 8]);
            s += (pa > pb) ? pa - pb : pb - pa;
        end
        return s;
    endfunction

    // Single transfer on the main instance; reports first result and latency.
    task automatic send_one(input logic [71:0] a, input logic [71:0] b,
                            input logic [5:0] tag,
                            output int sad, output int tg, output int lat);
        @(negedge clk);
        bus.win_a     = a;
        bus.win_b     = b;
        bus.in_tag    = tag;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        sad = -1;
        tg  = -1;
        for (int c = 1; c <= 20; c++) begin
            if (bus.out_valid) begin
                lat = c;
                sad = int'(bus.out_sad);
                tg  = int'(bus.out_tag);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", bus.out_valid);
        end
        n_chk++;
        if (bus.out_sad !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_sad got %0d want 0", bus.out_sad);
        end
        n_chk++;
        if (bus.out_tag !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_tag got %0d want 0", bus.out_tag);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic;
        int sad, tg, lat;
        send_one(fill(8'd10), fill(8'd7), 6'd5, sad, tg, lat);
        n_chk++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 5", lat);
        end
        n_chk++;
        if (sad !== 27) begin
            n_fail++;
            $display("FAIL basic_sad got %0d want 27", sad);
        end
        n_chk++;
        if (tg !== 5) begin
            n_fail++;
            $display("FAIL basic_tag got %0d want 5", tg);
        end
    endtask

    task automatic test_extremes;
        int sad, tg, lat;
        logic [71:0] pat;
        send_one(fill(8'd255), fill(8'd0), 6'd17, sad, tg, lat);
        n_chk++;
        if (sad !== 2295 || tg !== 17) begin
            n_fail++;
            $display("FAIL max_sad got %0d/%0d want 2295/17", sad, tg);
        end
        send_one(fill(8'd0), fill(8'd255), 6'd42, sad, tg, lat);
        n_chk++;
        if (sad !== 2295 || tg !== 42) begin
            n_fail++;
            $display("FAIL swap_sad got %0d/%0d want 2295/42", sad, tg);
        end
        pat = 72'h01_7f_80_ff_3c_c3_55_aa_00;
        send_one(pat, pat, 6'd63, sad, tg, lat);
        n_chk++;
        if (sad !== 0 || tg !== 63) begin
            n_fail++;
            $display("FAIL equal_sad got %0d/%0d want 0/63", sad, tg);
        end
        pat = 72'h00_00_00_00_00_00_00_00_ff;
        send_one(pat, fill(8'd1), 6'd1, sad, tg, lat);
        n_chk++;
        if (sad !== 262 || tg !== 1) begin
            n_fail++;
            $display("FAIL mixed_sad got %0d/%0d want 262/1", sad, tg);
        end
    endtask

    task automatic test_back_to_back;
        int          exp_q[$];
        int          tag_q[$];
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        pend = 1'b0;
        logic [71:0] a;
        logic [71:0] b;
        while ((sent < 20 || got < 20) && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra got sad %0d tag %0d want none",
                             bus.out_sad, bus.out_tag);
                end else if (bus.out_sad !== 12'(exp_q[0]) ||
                             bus.out_tag !== 6'(tag_q[0])) begin
                    n_fail++;
                    $display("FAIL b2b_result got %0d/%0d want %0d/%0d",
                             bus.out_sad, bus.out_tag, exp_q[0], tag_q[0]);
                end
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(tag_q.pop_front());
                got++;
            end
            if (!pend && sent < 20 && $urandom_range(0, 3) != 0) begin
                for (int i = 0; i < 9; i++) begin
                    a[i*8 +: 8] = 8'($urandom_range(0, 255));
                    b[i*8 +: 8] = 8'($urandom_range(0, 255));
                end
                bus.win_a  = a;
                bus.win_b  = b;
                bus.in_tag = 6'(sent + 20);
                pend = 1'b1;
            end
            bus.in_valid = pend;
            #1;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model_sad(bus.win_a, bus.win_b));
                tag_q.push_back(sent + 20);
                sent++;
                pend = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_chk++;
        if (got !== 20 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_count got %0d left %0d want 20 0 (cycles %0d)",
                     got, exp_q.size(), cyc);
        end
    endtask

    task automatic test_reset_midstream;
        logic seen = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.win_a     = fill(8'd10);
        bus.win_b     = fill(8'd7);
        bus.in_valid  = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            bus.in_tag = 6'(t);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10 && !bus.out_valid; c++) begin
            @(negedge clk);
        end
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_sad !== 12'd27 ||
            bus.out_tag !== 6'd1) begin
            n_fail++;
            $display("FAIL midrst_pre got %b/%0d/%0d want 1/27/1",
                     bus.out_valid, bus.out_sad, bus.out_tag);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_valid got %b want 0", bus.out_valid);
        end
        n_chk++;
        if (bus.out_sad !== 12'd0) begin
            n_fail++;
            $display("FAIL midrst_sad got %0d want 0", bus.out_sad);
        end
        n_chk++;
        if (bus.out_tag !== 6'd0) begin
            n_fail++;
            $display("FAIL midrst_tag got %0d want 0", bus.out_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_ready got %b want 1", bus.in_ready);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flush got output %b want none", seen);
        end
    endtask

    task automatic test_params;
        int lat4 = 0, lat5 = 0, lat10 = 0;
        int sad4 = -1, sad5 = -1, sad10 = -1;
        int exp10;
`ifdef SAD_SAT_EN
        exp10 = 1023;
`else
        exp10 = 247;
`endif
        @(negedge clk);
        for (int i = 0; i < 16; i++) bus4.win_a[i*8 +: 8] = 8'(i);
        for (int i = 0; i < 25; i++) bus5.win_a[i*8 +: 8] = 8'(i);
        bus4.win_b    = '0;
        bus5.win_b    = '0;
        bus10.win_a   = fill(8'd255);
        bus10.win_b   = fill(8'd0);
        bus4.in_valid  = 1'b1;
        bus5.in_valid  = 1'b1;
        bus10.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid  = 1'b0;
        bus5.in_valid  = 1'b0;
        bus10.in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (bus4.out_valid && lat4 == 0) begin
                lat4 = c;
                sad4 = int'(bus4.out_sad);
            end
            if (bus5.out_valid && lat5 == 0) begin
                lat5 = c;
                sad5 = int'(bus5.out_sad);
            end
            if (bus10.out_valid && lat10 == 0) begin
                lat10 = c;
                sad10 = int'(bus10.out_sad);
            end
            @(negedge clk);
        end
        n_chk++;
        if (lat4 !== 5) begin
            n_fail++;
            $display("FAIL win4_latency got %0d want 5", lat4);
        end
        n_chk++;
        if (sad4 !== 120) begin
            n_fail++;
            $display("FAIL win4_sad got %0d want 120", sad4);
        end
        n_chk++;
        if (lat5 !== 6) begin
            n_fail++;
            $display("FAIL win5_latency got %0d want 6", lat5);
        end
        n_chk++;
        if (sad5 !== 300) begin
            n_fail++;
            $display("FAIL win5_sad got %0d want 300", sad5);
        end
        n_chk++;
        if (lat10 !== 5) begin
            n_fail++;
            $display("FAIL out10_latency got %0d want 5", lat10);
        end
        n_chk++;
        if (sad10 !== exp10) begin
            n_fail++;
            $display("FAIL out10_sad got %0d want %0d", sad10, exp10);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.win_a     = '0;
        bus.win_b     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.win_a    = '0;
        bus4.win_b    = '0;
        bus4.in_tag   = 6'd0;
        bus4.out_ready = 1'b1;
        bus5.in_valid = 1'b0;
        bus5.win_a    = '0;
        bus5.win_b    = '0;
        bus5.in_tag   = 6'd0;
        bus5.out_ready = 1'b1;
        bus10.in_valid = 1'b0;
        bus10.win_a   = '0;
        bus10.win_b   = '0;
        bus10.in_tag  = 6'd0;
        bus10.out_ready = 1'b1;

        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_reset_midstream();
        test_params();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sad_pipe.md
# sad_pipe

Pipelined, streaming sum-of-absolute-differences engine for the stereo matcher. Accepts one pair of WIN×WIN pixel windows (left/right) per cycle through a valid/ready handshake and returns their SAD plus a pass-through tag (disparity index) a fixed number of cycles later. It sits between the window line-buffers and the disparity min-search and replaces the single-bit, purely combinational SAD with a multi-bit, registered adder tree.

## Interface
- WIN, 3, window edge length; N = WIN*WIN pixels per window (N ≥ 2)
- PIX_W, 8, bits per unsigned pixel
- TAG_W, 6, sideband tag width, carried unchanged
- OUT_W, 12, width of out_sad
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  window pair valid
- in_ready  out  1  pipeline can accept this cycle
- win_a  in  N*PIX_W  left window, row-major, pixel i at [i*PIX_W +: PIX_W]
- win_b  in  N*PIX_W  right window, same layout
- in_tag  in  TAG_W  sideband (disparity index)
- out_valid  out  1  out_sad/out_tag valid
- out_ready  in  1  downstream accepts
- out_sad  out  OUT_W  SAD result
- out_tag  out  TAG_W  tag of the same transfer

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stage 0: per-pixel |a_i − b_i|, unsigned, PIX_W bits, registered.
- Stages 1..L−1: binary adder tree, one level per stage, all registered; LEVELS = ceil(log2 N). Odd element count at a level: last element zero-extended and forwarded unchanged to the next level.
- Internal sum width SUM_W = PIX_W + ceil(log2 N); no overflow possible inside the tree (WIN=3, PIX_W=8: max 2295, SUM_W=12).
- Output conversion from SUM_W to OUT_W per Configuration. If OUT_W ≥ SUM_W: zero-extend, the macro has no effect.
- Each stage carries a valid bit and the tag alongside the data.
- Stall: single global advance enable adv = ~out_valid | out_ready. in_ready = adv (combinational). When adv=0 every stage, including valid bits and tags, holds. Bubbles are not collapsed.
- Reset (any time, incl. mid-stream): all valid bits, data and tag registers to 0 immediately; in-flight transfers are discarded, not completed.

## Timing
- Latency L = 1 + LEVELS cycles from input transfer to out_valid, with no stall (WIN=3: L=5).
- Throughput: one result per cycle while out_ready=1.
- Reset values: out_valid=0, out_sad=0, out_tag=0; in_ready=1 once rst deasserts and out_valid=0.
- in_ready may depend combinationally on out_ready. No other input-to-output combinational path.
- out_sad/out_tag stable while out_valid=1 and out_ready=0.
- Results leave in input order; tag always matches its own window pair.

## Configuration
- SAD_SAT_EN defined: sums > 2^OUT_W − 1 clamp to all-ones at the output stage.
- SAD_SAT_EN undefined: out_sad = low OUT_W bits of the sum (wrap).

## Structure
- Package sad_pkg: clog2 function, SUM_W/LEVELS derivation helpers, pixel and sum typedefs parametrised by PIX_W.
- Sub-module sad_tree_level: one registered adder-tree level (input count, width, enable, valid, tag), instantiated LEVELS times via generate.

## Test plan
- WIN=3, PIX_W=8: a all 10, b all 7, tag 5, out_ready=1 -> out_valid 5 cycles later, out_sad=27, out_tag=5.
- a all 255, b all 0 -> out_sad=2295; swap a/b -> 2295; a=b arbitrary -> 0.
- Back-to-back 20 random windows with random out_ready gaps -> results match software model in order, none dropped or duplicated, outputs held while stalled.
- Assert rst with 3 transfers in flight -> out_valid=0, out_sad=0, out_tag=0 the same cycle; nothing emitted after release until new input.
- OUT_W=10, a all 255, b all 0: with SAD_SAT_EN -> 1023; without -> 247.
- WIN=4, WIN=5 (even/odd N): a_i = i, b all 0 -> out_sad = N(N−1)/2 (120, 300) at L=5 and L=6.
